// File: rtl/cpu_pkg.sv
// Shared opcode, access-size and memory-stage state definitions
// for the RV64 multi-cycle CPU.
package cpu_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_DONE = 2'b10
   } mau_state_e;

endpackage

// File: rtl/mau_lane_align.sv
// Byte-lane steering for the memory stage: store mask/data placement,
// load lane extraction with sign/zero extension, and alignment check.
module mau_lane_align
   import cpu_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [2:0]        i_funct3,
   input  logic [2:0]        i_off,
   input  logic [DATA_W-1:0] i_store_data,
   input  logic [DATA_W-1:0] i_rdata,
   output logic [7:0]        o_wmask,
   output logic [DATA_W-1:0] o_wdata,
   output logic [DATA_W-1:0] o_load_val,
   output logic              o_misaligned
);

   logic [1:0]        w_size;
   logic              w_uns;
   logic [5:0]        w_shamt;
   logic [DATA_W-1:0] w_rsh;
   logic [7:0]        w_base;

   // funct3 111 has size bits 11, so it falls into the doubleword path
   assign w_size  = i_funct3[1:0];
   assign w_uns   = i_funct3[2];
   assign w_shamt = {i_off, 3'b000};
   assign w_rsh   = i_rdata >> w_shamt;
   assign o_wdata = i_store_data << w_shamt;
   assign o_wmask = w_base << i_off;

   always_comb begin
      w_base       = 8'h00;
      o_load_val   = '0;
      o_misaligned = 1'b0;
      unique case (w_size)
         SZ_B: begin
            w_base     = 8'h01;
            o_load_val = {{(DATA_W-8){w_rsh[7] & ~w_uns}}, w_rsh[7:0]};
         end
         SZ_H: begin
            w_base       = 8'h03;
            o_misaligned = i_off[0];
            o_load_val   = {{(DATA_W-16){w_rsh[15] & ~w_uns}}, w_rsh[15:0]};
         end
         SZ_W: begin
            w_base       = 8'h0F;
            o_misaligned = |i_off[1:0];
            o_load_val   = {{(DATA_W-32){w_rsh[31] & ~w_uns}}, w_rsh[31:0]};
         end
         default: begin
            w_base       = 8'hFF;
            o_misaligned = |i_off;
            o_load_val   = w_rsh;
         end
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: request/ack handshake with data memory for loads and
// stores, with timeout and misalignment abort; ALU passthrough otherwise.
module mem_access_unit
   import cpu_pkg::*;
#(
   parameter int DATA_W      = 64,
   parameter int INST_W      = 32,
   parameter int ADDR_W      = 64,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [INST_W-1:0] i_inst,
   input  logic [DATA_W-1:0] i_alu_result,
   input  logic [DATA_W-1:0] i_store_data,
   output logic              o_mem_req,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic [7:0]        o_mem_wmask,
   input  logic              i_mem_ack,
   input  logic [DATA_W-1:0] i_mem_rdata,
   output logic              o_done,
   output logic [DATA_W-1:0] o_wb_data,
   output logic              o_misaligned,
   output logic              o_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

   mau_state_e        r_state;
   mau_state_e        w_next;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_f3;
   logic [2:0]        r_off;

   logic [6:0]        w_opcode;
   logic              w_is_ld;
   logic              w_is_st;
   logic              w_is_mem;
   logic              w_idle;
   logic              w_accept;
   logic              w_cnt_lim;
   logic [2:0]        w_f3;
   logic [2:0]        w_off;
   logic [7:0]        w_wmask;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_load_val;
   logic              w_mis;
   logic              w_mem_ok;
   logic              w_unused_inst;

   assign w_opcode  = i_inst[6:0];
   assign w_is_ld   = (w_opcode == OP_LOAD);
   assign w_is_st   = (w_opcode == OP_STORE);
   assign w_is_mem  = w_is_ld | w_is_st;
   assign w_idle    = (r_state == S_IDLE);
   assign w_accept  = w_idle & i_valid;
   assign w_cnt_lim = (r_cnt == CNT_LIM);
   assign w_mem_ok  = w_is_mem & ~w_mis;

   assign w_unused_inst = &{1'b0, i_inst[INST_W-1:15], i_inst[11:7]};

   // live inputs drive the lanes at accept, latched copies during REQ
   assign w_f3  = w_idle ? i_inst[14:12]     : r_f3;
   assign w_off = w_idle ? i_alu_result[2:0] : r_off;

   mau_lane_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .i_funct3     (w_f3),
      .i_off        (w_off),
      .i_store_data (i_store_data),
      .i_rdata      (i_mem_rdata),
      .o_wmask      (w_wmask),
      .o_wdata      (w_wdata),
      .o_load_val   (w_load_val),
      .o_misaligned (w_mis)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (i_valid) w_next = w_mem_ok ? S_REQ : S_DONE;
         end
         S_REQ: begin
            if (i_mem_ack || w_cnt_lim) w_next = S_DONE;
         end
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_ready      <= 1'b1;
         o_mem_req    <= 1'b0;
         o_mem_we     <= 1'b0;
         o_mem_addr   <= '0;
         o_mem_wdata  <= '0;
         o_mem_wmask  <= '0;
         o_done       <= 1'b0;
         o_wb_data    <= '0;
         o_misaligned <= 1'b0;
         o_timeout    <= 1'b0;
         r_cnt        <= '0;
         r_f3         <= '0;
         r_off        <= '0;
      end else begin
         o_ready   <= (w_next == S_IDLE);
         o_mem_req <= (w_next == S_REQ);
         o_done    <= (w_next == S_DONE);
         if (w_accept) begin
            r_f3         <= i_inst[14:12];
            r_off        <= i_alu_result[2:0];
            r_cnt        <= '0;
            o_misaligned <= w_is_mem & w_mis;
            o_timeout    <= 1'b0;
            o_mem_addr   <= {i_alu_result[ADDR_W-1:3], 3'b000};
            o_mem_we     <= w_is_st & w_mem_ok;
            o_mem_wmask  <= (w_is_st & w_mem_ok) ? w_wmask : 8'h00;
            o_mem_wdata  <= (w_is_st & w_mem_ok) ? w_wdata : '0;
            o_wb_data    <= w_is_mem ? '0 : i_alu_result;
         end else if (r_state == S_REQ) begin
            r_cnt <= r_cnt + 1'b1;
            if (i_mem_ack) begin
               o_wb_data <= o_mem_we ? '0 : w_load_val;
            end else if (w_cnt_lim) begin
               o_timeout <= 1'b1;
               o_wb_data <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, passthrough,
// misalignment, timeout and reset during an outstanding request.
module tb_mem_access_unit;

   logic        i_clk = 1'b0;
   logic        i_rst = 1'b1;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [31:0] i_inst = '0;
   logic [63:0] i_alu_result = '0;
   logic [63:0] i_store_data = '0;
   logic        o_mem_req;
   logic        o_mem_we;
   logic [63:0] o_mem_addr;
   logic [63:0] o_mem_wdata;
   logic [7:0]  o_mem_wmask;
   logic        i_mem_ack = 1'b0;
   logic [63:0] i_mem_rdata = '0;
   logic        o_done;
   logic [63:0] o_wb_data;
   logic        o_misaligned;
   logic        o_timeout;

   int errs = 0;
   int checks = 0;

   int          lat, reqn;
   logic [63:0] c_addr, c_wdata;
   logic [7:0]  c_wmask;
   logic        c_we;

   mem_access_unit #(
      .DATA_W      (64),
      .INST_W      (32),
      .ADDR_W      (64),
      .TIMEOUT_CYC (4)
   ) dut (
      .i_clk        (i_clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_inst       (i_inst),
      .i_alu_result (i_alu_result),
      .i_store_data (i_store_data),
      .o_mem_req    (o_mem_req),
      .o_mem_we     (o_mem_we),
      .o_mem_addr   (o_mem_addr),
      .o_mem_wdata  (o_mem_wdata),
      .o_mem_wmask  (o_mem_wmask),
      .i_mem_ack    (i_mem_ack),
      .i_mem_rdata  (i_mem_rdata),
      .o_done       (o_done),
      .o_wb_data    (o_wb_data),
      .o_misaligned (o_misaligned),
      .o_timeout    (o_timeout)
   );

   always #5 i_clk = ~i_clk;

   // Issue one instruction; raise ack at negedge number ack_at (0 = never).
   // Returns latency in cycles to o_done and captured first-REQ outputs.
   task automatic run_txn(input logic [31:0] inst, input logic [63:0] alu,
                          input logic [63:0] st, input logic [63:0] rd,
                          input int ack_at);
      @(negedge i_clk);
      i_inst = inst; i_alu_result = alu; i_store_data = st;
      i_mem_rdata = rd; i_valid = 1'b1;
      lat = -1; reqn = 0;
      c_addr = '0; c_wdata = '0; c_wmask = '0; c_we = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(negedge i_clk);
         if (c == 1) begin
            i_valid = 1'b0; i_inst = '0;
            i_alu_result = '1; i_store_data = '1;
         end
         if (o_mem_req) begin
            if (reqn == 0) begin
               c_addr = o_mem_addr; c_wdata = o_mem_wdata;
               c_wmask = o_mem_wmask; c_we = o_mem_we;
            end
            reqn++;
         end
         if (o_done) begin
            lat = c;
            break;
         end
         if (ack_at != 0 && c == ack_at) i_mem_ack = 1'b1;
      end
      i_mem_ack = 1'b0;
   endtask

   task automatic test_reset;
      i_rst = 1'b1;
      repeat (3) @(negedge i_clk);
      checks++; if (o_ready !== 1'b1) begin errs++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
      checks++; if (o_mem_req !== 1'b0) begin errs++; $display("FAIL rst_req got=%b exp=0", o_mem_req); end
      checks++; if (o_done !== 1'b0) begin errs++; $display("FAIL rst_done got=%b exp=0", o_done); end
      checks++; if (o_wb_data !== 64'h0) begin errs++; $display("FAIL rst_wb got=%h exp=0", o_wb_data); end
      checks++; if (o_mem_wmask !== 8'h00) begin errs++; $display("FAIL rst_wmask got=%h exp=00", o_mem_wmask); end
      checks++; if ({o_misaligned, o_timeout, o_mem_we} !== 3'b000) begin errs++; $display("FAIL rst_flags got=%b exp=000", {o_misaligned, o_timeout, o_mem_we}); end
      i_rst = 1'b0;
   endtask

   task automatic test_store;
      run_txn(32'h00003023, 64'h1008, 64'h1122334455667788, 64'h0, 4);
      checks++; if (lat !== 5) begin errs++; $display("FAIL sd_lat got=%0d exp=5", lat); end
      checks++; if (reqn !== 4) begin errs++; $display("FAIL sd_reqn got=%0d exp=4", reqn); end
      checks++; if (c_addr !== 64'h1008) begin errs++; $display("FAIL sd_addr got=%h exp=1008", c_addr); end
      checks++; if (c_wmask !== 8'hFF) begin errs++; $display("FAIL sd_wmask got=%h exp=ff", c_wmask); end
      checks++; if (c_wdata !== 64'h1122334455667788) begin errs++; $display("FAIL sd_wdata got=%h exp=1122334455667788", c_wdata); end
      checks++; if (c_we !== 1'b1) begin errs++; $display("FAIL sd_we got=%b exp=1", c_we); end
      checks++; if ({o_misaligned, o_timeout} !== 2'b00) begin errs++; $display("FAIL sd_flags got=%b exp=00", {o_misaligned, o_timeout}); end
      checks++; if (o_wb_data !== 64'h0) begin errs++; $display("FAIL sd_wb got=%h exp=0", o_wb_data); end

      run_txn(32'h00002023, 64'h3004, 64'hDEADBEEF, 64'h0, 1);
      checks++; if (lat !== 2) begin errs++; $display("FAIL sw_lat got=%0d exp=2", lat); end
      checks++; if (c_wmask !== 8'hF0) begin errs++; $display("FAIL sw_wmask got=%h exp=f0", c_wmask); end
      checks++; if (c_wdata !== 64'hDEADBEEF00000000) begin errs++; $display("FAIL sw_wdata got=%h exp=deadbeef00000000", c_wdata); end
      checks++; if (c_addr !== 64'h3000) begin errs++; $display("FAIL sw_addr got=%h exp=3000", c_addr); end

      run_txn(32'h00000023, 64'h3003, 64'h11223344556677AB, 64'h0, 1);
      checks++; if (c_wmask !== 8'h08) begin errs++; $display("FAIL sb_wmask got=%h exp=08", c_wmask); end
      checks++; if (c_wdata !== 64'h44556677AB000000) begin errs++; $display("FAIL sb_wdata got=%h exp=44556677ab000000", c_wdata); end
   endtask

   task automatic test_load;
      run_txn(32'h00000003, 64'h2005, 64'h0, 64'h000080FF00000000, 2);
      checks++; if (o_wb_data !== 64'hFFFFFFFFFFFFFF80) begin errs++; $display("FAIL lb_wb got=%h exp=ffffffffffffff80", o_wb_data); end
      checks++; if (c_addr !== 64'h2000) begin errs++; $display("FAIL lb_addr got=%h exp=2000", c_addr); end
      checks++; if ({c_we, c_wmask} !== 9'h000) begin errs++; $display("FAIL lb_we_mask got=%h exp=000", {c_we, c_wmask}); end
      checks++; if (lat !== 3) begin errs++; $display("FAIL lb_lat got=%0d exp=3", lat); end

      run_txn(32'h00004003, 64'h2005, 64'h0, 64'h000080FF00000000, 1);
      checks++; if (o_wb_data !== 64'h80) begin errs++; $display("FAIL lbu_wb got=%h exp=80", o_wb_data); end

      run_txn(32'h00001003, 64'h2004, 64'h0, 64'h000080FF00000000, 1);
      checks++; if (o_wb_data !== 64'hFFFFFFFFFFFF80FF) begin errs++; $display("FAIL lh_wb got=%h exp=ffffffffffff80ff", o_wb_data); end

      run_txn(32'h00002003, 64'h2004, 64'h0, 64'h000080FF00000000, 1);
      checks++; if (o_wb_data !== 64'h80FF) begin errs++; $display("FAIL lw_wb got=%h exp=80ff", o_wb_data); end

      run_txn(32'h00007003, 64'h5000, 64'h0, 64'hFEDCBA9876543210, 1);
      checks++; if (o_wb_data !== 64'hFEDCBA9876543210) begin errs++; $display("FAIL f3_111_wb got=%h exp=fedcba9876543210", o_wb_data); end
   endtask

   task automatic test_misaligned;
      run_txn(32'h00002003, 64'h3006, 64'h0, 64'h0, 1);
      checks++; if (lat !== 1) begin errs++; $display("FAIL mis_lat got=%0d exp=1", lat); end
      checks++; if (reqn !== 0) begin errs++; $display("FAIL mis_reqn got=%0d exp=0", reqn); end
      checks++; if (o_misaligned !== 1'b1) begin errs++; $display("FAIL mis_flag got=%b exp=1", o_misaligned); end
      run_txn(32'h00001023, 64'h3001, 64'h0, 64'h0, 1);
      checks++; if ({reqn, o_misaligned} !== {32'd0, 1'b1}) begin errs++; $display("FAIL mis_sh reqn=%0d flag=%b exp 0/1", reqn, o_misaligned); end
   endtask

   task automatic test_passthrough;
      run_txn(32'h00000033, 64'h42, 64'h0, 64'h0, 1);
      checks++; if (lat !== 1) begin errs++; $display("FAIL add_lat got=%0d exp=1", lat); end
      checks++; if (o_wb_data !== 64'h42) begin errs++; $display("FAIL add_wb got=%h exp=42", o_wb_data); end
      checks++; if (reqn !== 0) begin errs++; $display("FAIL add_reqn got=%0d exp=0", reqn); end
      checks++; if (o_misaligned !== 1'b0) begin errs++; $display("FAIL add_mis_clr got=%b exp=0", o_misaligned); end
      @(negedge i_clk);
      checks++; if ({o_done, o_ready} !== 2'b01) begin errs++; $display("FAIL add_after got=%b exp=01", {o_done, o_ready}); end
      checks++; if (o_wb_data !== 64'h42) begin errs++; $display("FAIL add_hold got=%h exp=42", o_wb_data); end
   endtask

   task automatic test_timeout;
      run_txn(32'h00003003, 64'h4000, 64'h0, 64'h0123456789ABCDEF, 0);
      checks++; if (lat !== 5) begin errs++; $display("FAIL tmo_lat got=%0d exp=5", lat); end
      checks++; if (reqn !== 4) begin errs++; $display("FAIL tmo_reqn got=%0d exp=4", reqn); end
      checks++; if (o_timeout !== 1'b1) begin errs++; $display("FAIL tmo_flag got=%b exp=1", o_timeout); end
      checks++; if (o_wb_data !== 64'h0) begin errs++; $display("FAIL tmo_wb got=%h exp=0", o_wb_data); end

      run_txn(32'h00003003, 64'h4000, 64'h0, 64'h0123456789ABCDEF, 4);
      checks++; if (lat !== 5) begin errs++; $display("FAIL ack4_lat got=%0d exp=5", lat); end
      checks++; if (o_timeout !== 1'b0) begin errs++; $display("FAIL ack4_tmo got=%b exp=0", o_timeout); end
      checks++; if (o_wb_data !== 64'h0123456789ABCDEF) begin errs++; $display("FAIL ack4_wb got=%h exp=0123456789abcdef", o_wb_data); end
   endtask

   task automatic test_reset_mid_req;
      int seen;
      @(negedge i_clk);
      i_inst = 32'h00003003; i_alu_result = 64'h6000; i_valid = 1'b1;
      @(negedge i_clk);
      checks++; if (o_mem_req !== 1'b1) begin errs++; $display("FAIL rmr_req1 got=%b exp=1", o_mem_req); end
      @(negedge i_clk);
      checks++; if ({o_mem_req, o_done, o_ready} !== 3'b100) begin errs++; $display("FAIL rmr_ignore_valid got=%b exp=100", {o_mem_req, o_done, o_ready}); end
      i_valid = 1'b0; i_rst = 1'b1;
      @(negedge i_clk);
      checks++; if ({o_mem_req, o_ready} !== 2'b01) begin errs++; $display("FAIL rmr_after_rst got=%b exp=01", {o_mem_req, o_ready}); end
      i_rst = 1'b0;
      seen = 0;
      repeat (6) begin
         @(negedge i_clk);
         if (o_mem_req || o_done || !o_ready) seen++;
      end
      checks++; if (seen !== 0) begin errs++; $display("FAIL rmr_no_second_txn got=%0d exp=0", seen); end
   endtask

   initial begin
      test_reset();
      test_store();
      test_load();
      test_misaligned();
      test_passthrough();
      test_timeout();
      test_reset_mid_req();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory stage directly downstream of the ALU in the RV64 multi-cycle CPU.
- Takes the registered ALU result (effective address or arithmetic result), the instruction and the rs2 value.
- For loads and stores, runs a request/acknowledge transaction with the data memory, handling byte-lane selection, masking, extension, alignment and timeout.
- For all other opcodes, passes the ALU result through to writeback.

Parameters:
- DATA_W, 64, datapath and memory word width (fixed at 64; 8 byte lanes).
- INST_W, 32, instruction width.
- ADDR_W, 64, memory address width.
- TIMEOUT_CYC, 255, maximum cycles spent in REQ without ack before aborting; must be ≥1.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  start pulse from the control FSM; accepted only when o_ready=1.
- o_ready  out  1  high in IDLE.
- i_inst  in  INST_W  instruction; opcode [6:0], funct3 [14:12].
- i_alu_result  in  DATA_W  ALU output; this is the byte address for load/store.
- i_store_data  in  DATA_W  rs2 value.
- o_mem_req  out  1  memory request; held high until ack.
- o_mem_we  out  1  1=store, 0=load.
- o_mem_addr  out  ADDR_W  doubleword-aligned address {addr[ADDR_W-1:3],3'b000}.
- o_mem_wdata  out  DATA_W  store data shifted into its byte lanes.
- o_mem_wmask  out  8  byte-lane write enables; 0 for loads.
- i_mem_ack  in  1  memory completion; sampled only in REQ.
- i_mem_rdata  in  DATA_W  read data; valid in the ack cycle.
- o_done  out  1  one-cycle completion pulse.
- o_wb_data  out  DATA_W  writeback value; held until the next accept.
- o_misaligned  out  1  qualifies o_done; access aborted for misalignment.
- o_timeout  out  1  qualifies o_done; memory did not ack.

Behaviour:
- Reset: state=IDLE. o_ready=1. o_mem_req, o_mem_we, o_done, o_misaligned, o_timeout = 0. o_mem_addr, o_mem_wdata, o_wb_data = 0. o_mem_wmask=0. Timeout counter=0.
- All outputs are registered. Inputs are latched at accept; i_inst, i_alu_result and i_store_data may change afterwards.
- States: IDLE, REQ, DONE.
- IDLE, i_valid=1:
  - Load (0000011) or store (0100011), aligned → REQ.
  - Load or store, misaligned → DONE with o_misaligned=1 and no memory request.
  - Any other opcode → DONE with o_wb_data=i_alu_result.
- REQ:
  - o_mem_req=1. Counter increments each cycle.
  - i_mem_ack=1 → DONE. For loads, o_wb_data = extracted i_mem_rdata; for stores, o_wb_data=0.
  - Counter reaches TIMEOUT_CYC-1 with no ack → DONE with o_timeout=1, o_wb_data=0.
  - Ack on the same edge as the timeout limit → ack wins; o_timeout=0.
- DONE: o_done=1 for exactly one cycle, o_mem_req=0, then → IDLE.
- Latency from accept edge to o_done:
  - Non-memory or misaligned: 1 cycle.
  - Memory access: 2 cycles + ack wait.
- Alignment, with off=addr[2:0]:
  - byte: always aligned.
  - half: off[0]=0.
  - word: off[1:0]=0.
  - double: off=0.
- Load funct3 000/001/010/011 (lb/lh/lw/ld): lane i_mem_rdata[8*off +: size], sign-extended to 64 bits.
- Load funct3 100/101/110 (lbu/lhu/lwu): same lane, zero-extended. funct3 111 is treated as ld.
- Store funct3 000/001/010/011 (sb/sh/sw/sd):
  - o_mem_wmask = (1/3/F/FF) << off.
  - o_mem_wdata = i_store_data << (8*off).
- i_valid outside IDLE is ignored, with no queuing. i_mem_ack outside REQ is ignored.
- Reset asserted mid-REQ: o_mem_req=0 the following cycle and state returns to IDLE. The memory must tolerate an abandoned request.
- o_misaligned and o_timeout are cleared at the next accept.

Decomposition:
- Shared package (cpu_pkg):
  - Opcode constants OP_LOAD, OP_STORE, OP_BRANCH, OP_OPIMM, OP_OP.
  - funct3 size codes.
  - State enum for IDLE/REQ/DONE.
- One combinational sub-module, mau_lane_align: given funct3, off, store data and read data, it produces wmask, shifted wdata, the extended load value and a misaligned flag.
- FSM and counter live in the top module.

Test Plan:
- sd: addr=0x1008, store=0x1122334455667788, ack after 3 cycles → o_mem_addr=0x1008, wmask=0xFF, wdata=store, o_done 5 cycles after accept, no flags.
- lb: addr=0x2005, rdata=0x0000_80FF_0000_0000 → lane 5=0x80, o_wb_data=0xFFFFFFFFFFFFFF80. Same access as lbu → 0x80.
- sw: addr=0x3004, store=0xDEADBEEF → wmask=0xF0, wdata=0xDEADBEEF_00000000. lw at 0x3006 → o_misaligned=1 after 1 cycle, o_mem_req never asserted.
- add (opcode 0110011), ALU result 0x42 → o_done 1 cycle after accept, o_wb_data=0x42, o_mem_req stays 0.
- ld with ack never asserted, TIMEOUT_CYC=4 → o_mem_req high exactly 4 cycles, then o_done with o_timeout=1, o_wb_data=0. Ack on the 4th REQ cycle → normal completion.
- Reset pulse during REQ, plus i_valid during REQ → o_mem_req low next cycle, state IDLE, o_ready=1. The extra i_valid produces no second transaction.
